// File: rtl/alu_slice_pkg.sv
// Shared encodings for the alu_slice_rpt datapath slice: microinstruction
// source/function/destination codes, destination shift masks and the repeat
// sequencer state type.
package alu_slice_pkg;

  typedef enum logic [2:0] {
    SRC_AQ = 3'd0, SRC_AB = 3'd1, SRC_ZQ = 3'd2, SRC_ZB = 3'd3,
    SRC_ZA = 3'd4, SRC_DA = 3'd5, SRC_DQ = 3'd6, SRC_DZ = 3'd7
  } src_e;

  typedef enum logic [2:0] {
    FN_ADD = 3'd0, FN_SUBR = 3'd1, FN_SUBS = 3'd2, FN_OR    = 3'd3,
    FN_AND = 3'd4, FN_NOTRS = 3'd5, FN_EXOR = 3'd6, FN_EXNOR = 3'd7
  } func_e;

  typedef enum logic [2:0] {
    DST_QREG  = 3'd0, DST_NOP  = 3'd1, DST_RAMA  = 3'd2, DST_RAMF = 3'd3,
    DST_RAMQD = 3'd4, DST_RAMD = 3'd5, DST_RAMQU = 3'd6, DST_RAMU = 3'd7
  } dst_e;

  // One bit per destination code, indexed by the code itself.
  localparam logic [7:0] RAM_WR_MASK = 8'b1111_1100;
  localparam logic [7:0] RAM_DN_MASK = 8'b0011_0000;
  localparam logic [7:0] RAM_UP_MASK = 8'b1100_0000;
  localparam logic [7:0] Q_DN_MASK   = 8'b0001_0000;
  localparam logic [7:0] Q_UP_MASK   = 8'b0100_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/alu_slice_regfile.sv
// REGS x WIDTH register file: two combinational read ports (A, B) and one
// synchronous write port at the B address. Contents are deliberately not reset.
// Ports: clk, a_addr, b_addr, we, wdata in; a_data, b_data out.
module alu_slice_regfile #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned REGS  = 16
) (
  input  logic                     clk,
  input  logic [$clog2(REGS)-1:0]  a_addr,
  input  logic [$clog2(REGS)-1:0]  b_addr,
  input  logic                     we,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         a_data,
  output logic [WIDTH-1:0]         b_data
);

  logic [WIDTH-1:0] mem [REGS];

  assign a_data = mem[a_addr];
  assign b_data = mem[b_addr];

  // Write lands at the edge, so a same-cycle read of B still sees the old value.
  always_ff @(posedge clk) begin
    if (we) mem[b_addr] <= wdata;
  end

endmodule

// File: rtl/alu_slice_rpt.sv
// alu_slice_rpt: WIDTH-bit 2901-style ALU slice with register file, Q register,
// RAM/Q shifters and an optional repeat sequencer that re-executes one latched
// microinstruction count+1 times.
// Build option: ALU_SLICE_RPT_REPEAT_EN enables the sequencer; otherwise busy=0,
// done=start and every instruction executes live.
// Ports: clk, rst_n, i, a_addr, b_addr, d, cin, oe_n, shift-ins, start, count in;
// y (tri-state), cout, g_n, p_n, ovr, f_msb, f_zero, shift-outs, busy, done out.
module alu_slice_rpt
  import alu_slice_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned REGS  = 16,
  parameter int unsigned CW    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8:0]               i,
  input  logic [$clog2(REGS)-1:0]  a_addr,
  input  logic [$clog2(REGS)-1:0]  b_addr,
  input  logic [WIDTH-1:0]         d,
  input  logic                     cin,
  input  logic                     oe_n,
  input  logic                     ram_lsb_i,
  input  logic                     ram_msb_i,
  input  logic                     q_lsb_i,
  input  logic                     q_msb_i,
  output logic                     ram_lsb_o,
  output logic                     ram_msb_o,
  output logic                     q_lsb_o,
  output logic                     q_msb_o,
  output logic [WIDTH-1:0]         y,
  output logic                     cout,
  output logic                     g_n,
  output logic                     p_n,
  output logic                     ovr,
  output logic                     f_msb,
  output logic                     f_zero,
  input  logic                     start,
  input  logic [CW-1:0]            count,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW  = $clog2(REGS);
  localparam int unsigned WP1 = WIDTH + 1;

  // Effective (live or latched) instruction operands
  logic [8:0]       i_e;
  logic [AW-1:0]    a_e, b_e;
  logic [WIDTH-1:0] d_e;
  logic             cin_e;

`ifdef ALU_SLICE_RPT_REPEAT_EN
  seq_state_e       state_q, state_d;
  logic [CW-1:0]    rem_q;
  logic             run_c, done_c;
  logic [8:0]       i_l;
  logic [AW-1:0]    a_l, b_l;
  logic [WIDTH-1:0] d_l;
  logic             cin_l;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: iteration 0 runs in IDLE, so count==0 never enters RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && (count != '0)) state_d = ST_RUN;
      ST_RUN:  if (rem_q == '0)            state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer outputs
  always_comb begin
    run_c  = 1'b0;
    done_c = 1'b0;
    case (state_q)
      ST_IDLE: done_c = start && (count == '0);
      ST_RUN: begin
        run_c  = 1'b1;
        done_c = (rem_q == '0);
      end
      default: ;
    endcase
  end

  // Remaining-iteration counter and instruction latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      i_l   <= '0;
      a_l   <= '0;
      b_l   <= '0;
      d_l   <= '0;
      cin_l <= 1'b0;
    end else if ((state_q == ST_IDLE) && start) begin
      rem_q <= (count == '0) ? '0 : count - CW'(1);
      i_l   <= i;
      a_l   <= a_addr;
      b_l   <= b_addr;
      d_l   <= d;
      cin_l <= cin;
    end else if ((state_q == ST_RUN) && (rem_q != '0)) begin
      rem_q <= rem_q - CW'(1);
    end
  end

  assign i_e   = run_c ? i_l   : i;
  assign a_e   = run_c ? a_l   : a_addr;
  assign b_e   = run_c ? b_l   : b_addr;
  assign d_e   = run_c ? d_l   : d;
  assign cin_e = run_c ? cin_l : cin;
  assign busy  = run_c;
  assign done  = done_c & rst_n;
`else
  logic unused_count;
  assign unused_count = ^count;
  assign i_e   = i;
  assign a_e   = a_addr;
  assign b_e   = b_addr;
  assign d_e   = d;
  assign cin_e = cin;
  assign busy  = 1'b0;
  assign done  = start & rst_n;
`endif

  src_e             src;
  func_e            fn;
  logic [2:0]       dst;
  logic [WIDTH-1:0] a_data, b_data, q_q, q_d;
  logic [WIDTH-1:0] r, s, rp, sp, f, b_wdata, y_c;
  logic [WIDTH:0]   sum;
  logic             arith, c_msb, gg, ram_we;

  assign src = src_e'(i_e[2:0]);
  assign fn  = func_e'(i_e[5:3]);
  assign dst = i_e[8:6];

  alu_slice_regfile #(.WIDTH(WIDTH), .REGS(REGS)) u_regfile (
    .clk    (clk),
    .a_addr (a_e),
    .b_addr (b_e),
    .we     (ram_we),
    .wdata  (b_wdata),
    .a_data (a_data),
    .b_data (b_data)
  );

  // Operand select
  always_comb begin
    r = '0;
    s = '0;
    case (src)
      SRC_AQ: begin r = a_data; s = q_q;    end
      SRC_AB: begin r = a_data; s = b_data; end
      SRC_ZQ: s = q_q;
      SRC_ZB: s = b_data;
      SRC_ZA: s = a_data;
      SRC_DA: begin r = d_e;    s = a_data; end
      SRC_DQ: begin r = d_e;    s = q_q;    end
      SRC_DZ: r = d_e;
      default: ;
    endcase
  end

  // Subtracts invert one operand; lookahead terms use the inverted operands
  assign rp    = (fn == FN_SUBR) ? ~r : r;
  assign sp    = (fn == FN_SUBS) ? ~s : s;
  assign sum   = {1'b0, rp} + {1'b0, sp} + WP1'(cin_e);
  assign c_msb = sum[WIDTH-1] ^ rp[WIDTH-1] ^ sp[WIDTH-1];
  assign arith = (fn == FN_ADD) || (fn == FN_SUBR) || (fn == FN_SUBS);

  // Function unit
  always_comb begin
    f = sum[WIDTH-1:0];
    case (fn)
      FN_OR:    f = r | s;
      FN_AND:   f = r & s;
      FN_NOTRS: f = ~r & s;
      FN_EXOR:  f = r ^ s;
      FN_EXNOR: f = ~(r ^ s);
      default:  ;
    endcase
  end

  // Ripple form of the group generate over the whole width
  always_comb begin
    gg = 1'b0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      gg = (rp[k] & sp[k]) | ((rp[k] | sp[k]) & gg);
    end
  end

  assign cout   = arith & sum[WIDTH];
  assign ovr    = arith & (c_msb ^ sum[WIDTH]);
  assign g_n    = ~gg;
  assign p_n    = ~&(rp | sp);
  assign f_msb  = f[WIDTH-1];
  assign f_zero = (f == '0);

  // Destination: RAM write data, shift-outs, Y select, Q next value
  assign ram_we    = RAM_WR_MASK[dst];
  assign ram_lsb_o = RAM_DN_MASK[dst] & f[0];
  assign ram_msb_o = RAM_UP_MASK[dst] & f[WIDTH-1];
  assign q_lsb_o   = Q_DN_MASK[dst] & q_q[0];
  assign q_msb_o   = Q_UP_MASK[dst] & q_q[WIDTH-1];
  assign y_c       = (dst == DST_RAMA) ? a_data : f;
  assign y         = oe_n ? {WIDTH{1'bz}} : y_c;

  always_comb begin
    b_wdata = f;
    if (RAM_DN_MASK[dst])      b_wdata = {ram_msb_i, f[WIDTH-1:1]};
    else if (RAM_UP_MASK[dst]) b_wdata = {f[WIDTH-2:0], ram_lsb_i};
  end

  always_comb begin
    q_d = q_q;
    if (dst == DST_QREG)     q_d = f;
    else if (Q_DN_MASK[dst]) q_d = {q_msb_i, q_q[WIDTH-1:1]};
    else if (Q_UP_MASK[dst]) q_d = {q_q[WIDTH-2:0], q_lsb_i};
  end

  // Q register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: tb/tb_alu_slice_rpt.sv
// Self-checking bench for alu_slice_rpt (WIDTH=16, REGS=16, CW=6): directed
// scenarios plus random microinstructions against a behavioural model.
module tb_alu_slice_rpt;

  localparam int unsigned M = 32'h0000_FFFF;
`ifdef ALU_SLICE_RPT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic        clk, rst_n;
  logic [8:0]  i;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] d;
  logic        cin, oe_n, ram_lsb_i, ram_msb_i, q_lsb_i, q_msb_i, start;
  logic [5:0]  count;
  wire  [15:0] y;
  logic        ram_lsb_o, ram_msb_o, q_lsb_o, q_msb_o;
  logic        cout, g_n, p_n, ovr, f_msb, f_zero, busy, done;

  alu_slice_rpt dut (
    .clk(clk), .rst_n(rst_n), .i(i), .a_addr(a_addr), .b_addr(b_addr),
    .d(d), .cin(cin), .oe_n(oe_n),
    .ram_lsb_i(ram_lsb_i), .ram_msb_i(ram_msb_i), .q_lsb_i(q_lsb_i), .q_msb_i(q_msb_i),
    .ram_lsb_o(ram_lsb_o), .ram_msb_o(ram_msb_o), .q_lsb_o(q_lsb_o), .q_msb_o(q_msb_o),
    .y(y), .cout(cout), .g_n(g_n), .p_n(p_n), .ovr(ovr), .f_msb(f_msb), .f_zero(f_zero),
    .start(start), .count(count), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int unsigned mem [16];
  int unsigned mq;
  int          m_left;
  logic [8:0]  l_i;
  int unsigned l_a, l_b, l_d;
  bit          l_cin;
  // Effects pending for the next rising edge
  bit          p_we, p_qld, p_start;
  int unsigned p_waddr, p_wdata, p_q, p_cnt;
  logic [8:0]  p_i;
  int unsigned p_a, p_b, p_d;
  bit          p_cin;

  function automatic logic [8:0] ins(input int unsigned dst, fn, src);
    return {3'(dst), 3'(fn), 3'(src)};
  endfunction

  task automatic drive(input logic [8:0] ii, input int unsigned aa, bb, dd, input bit cc);
    i = ii; a_addr = 4'(aa); b_addr = 4'(bb); d = 16'(dd); cin = cc;
    oe_n = 1'b0; start = 1'b0; count = '0;
    ram_lsb_i = 1'b0; ram_msb_i = 1'b0; q_lsb_i = 1'b0; q_msb_i = 1'b0;
  endtask

  // Predict this cycle's outputs from the model, compare, and stage the edge effects.
  task automatic eval_check();
    logic [8:0]  ei;
    int unsigned ea, eb, ed, av, bv, r, s, rp, sp, full, f, yv, fn, dst;
    bit          ec, co, ov, gn, pn, fm, fz, rlo, rmo, qlo, qmo, eb_busy, eb_done;
    #1;
    if (m_left > 0) begin
      ei = l_i; ea = l_a; eb = l_b; ed = l_d; ec = l_cin;
    end else begin
      ei = i; ea = a_addr; eb = b_addr; ed = d; ec = cin;
    end
    av = mem[ea];
    bv = mem[eb];
    r = 0; s = 0;
    case (ei[2:0])
      3'd0: begin r = av; s = mq; end
      3'd1: begin r = av; s = bv; end
      3'd2: s = mq;
      3'd3: s = bv;
      3'd4: s = av;
      3'd5: begin r = ed; s = av; end
      3'd6: begin r = ed; s = mq; end
      default: r = ed;
    endcase
    fn  = ei[5:3];
    dst = ei[8:6];
    rp = (fn == 1) ? (~r & M) : r;
    sp = (fn == 2) ? (~s & M) : s;
    gn = ((rp + sp) >> 16) == 0;
    pn = (rp | sp) != M;
    if (fn <= 2) begin
      full = rp + sp + (ec ? 1 : 0);
      f  = full & M;
      co = (full >> 16) != 0;
      ov = ((rp >> 15) == (sp >> 15)) && ((f >> 15) != (rp >> 15));
    end else begin
      case (fn)
        3: f = r | s;
        4: f = r & s;
        5: f = ~r & s & M;
        6: f = r ^ s;
        default: f = ~(r ^ s) & M;
      endcase
      co = 1'b0;
      ov = 1'b0;
    end
    fm  = (f >> 15) != 0;
    fz  = (f == 0);
    yv  = (dst == 2) ? av : f;
    rlo = (dst == 4 || dst == 5) && ((f & 1) != 0);
    rmo = (dst >= 6) && fm;
    qlo = (dst == 4) && ((mq & 1) != 0);
    qmo = (dst == 6) && ((mq >> 15) != 0);
    eb_busy = (m_left > 0);
    eb_done = REP ? ((m_left == 0 && start && count == 0) || m_left == 1) : start;
    if (oe_n) chk("y_hiz", 32'(y), {16'h0, 16'hzzzz});
    else      chk("y", 32'(y), yv);
    chk("flags",
        {20'h0, cout, g_n, p_n, ovr, f_msb, f_zero, ram_lsb_o, ram_msb_o, q_lsb_o, q_msb_o, busy, done},
        {20'h0, co, gn, pn, ov, fm, fz, rlo, rmo, qlo, qmo, eb_busy, eb_done});
    p_we    = dst >= 2;
    p_waddr = eb;
    if (dst == 4 || dst == 5)      p_wdata = (f >> 1) | (32'(ram_msb_i) << 15);
    else if (dst >= 6)             p_wdata = ((f << 1) & M) | 32'(ram_lsb_i);
    else                           p_wdata = f;
    p_qld = (dst == 0 || dst == 4 || dst == 6);
    if (dst == 0)      p_q = f;
    else if (dst == 4) p_q = (mq >> 1) | (32'(q_msb_i) << 15);
    else               p_q = ((mq << 1) & M) | 32'(q_lsb_i);
    p_start = REP && start && (m_left == 0);
    p_cnt = count; p_i = i; p_a = a_addr; p_b = b_addr; p_d = d; p_cin = cin;
  endtask

  task automatic advance();
    @(posedge clk);
    if (p_we)  mem[p_waddr] = p_wdata;
    if (p_qld) mq = p_q;
    if (m_left > 0) m_left--;
    else if (p_start) begin
      l_i = p_i; l_a = p_a; l_b = p_b; l_d = p_d; l_cin = p_cin;
      m_left = int'(p_cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    int bcnt, dcnt;
    int unsigned v;
    rst_n = 1'b0;
    mq = 0; m_left = 0;
    foreach (mem[k]) mem[k] = 0;
    drive(ins(1, 3, 2), 0, 0, 0, 0);
    start = 1'b1;
    #12;
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Q load from D
    drive(ins(0, 0, 7), 0, 0, 16'h1234, 0);
    eval_check();
    chk("tp1_y", 32'(y), 32'h1234);
    chk("tp1_fz", 32'(f_zero), 32'h0);
    chk("tp1_cout", 32'(cout), 32'h0);
    advance();
    drive(ins(1, 3, 2), 0, 0, 0, 0);
    eval_check();
    chk("tp1_q", 32'(y), 32'h1234);
    advance();

    // Register file init
    for (int k = 0; k < 16; k++) begin
      case (k)
        1: v = 32'h7FFF;
        2: v = 32'h0001;
        3: v = 32'h0000;
        5: v = 32'h0005;
        6: v = 32'h0F0F;
        default: v = ((k * 32'h1357) ^ 32'hA5A5) & M;
      endcase
      drive(ins(3, 0, 7), 0, k, v, 0);
      eval_check();
      advance();
    end

    // Signed overflow on ADD, then read-back through B
    drive(ins(3, 0, 1), 1, 2, 0, 0);
    eval_check();
    chk("tp2_y", 32'(y), 32'h8000);
    chk("tp2_ovr", 32'(ovr), 32'h1);
    chk("tp2_cout", 32'(cout), 32'h0);
    chk("tp2_fmsb", 32'(f_msb), 32'h1);
    advance();
    drive(ins(1, 3, 3), 0, 2, 0, 0);
    eval_check();
    chk("tp2_rd", 32'(y), 32'h8000);
    advance();

    // SUBR zero result, then OR
    drive(ins(1, 1, 5), 5, 0, 5, 1);
    eval_check();
    chk("tp3_y", 32'(y), 32'h0);
    chk("tp3_fz", 32'(f_zero), 32'h1);
    chk("tp3_cout", 32'(cout), 32'h1);
    advance();
    drive(ins(1, 3, 5), 6, 0, 16'hF0F0, 0);
    eval_check();
    chk("tp3_or", 32'(y), 32'hFFFF);
    chk("tp3_or_cv", {30'h0, cout, ovr}, 32'h0);
    advance();

    // RAM down shift
    drive(ins(5, 3, 7), 0, 7, 3, 0);
    ram_msb_i = 1'b1;
    eval_check();
    chk("tp4_rlo", 32'(ram_lsb_o), 32'h1);
    advance();
    drive(ins(1, 3, 3), 0, 7, 0, 0);
    eval_check();
    chk("tp4_b", 32'(y), 32'h8001);
    advance();

    // Q up shift
    drive(ins(0, 0, 7), 0, 0, 16'h8000, 0);
    eval_check();
    advance();
    drive(ins(6, 0, 7), 0, 8, 0, 0);
    eval_check();
    chk("tp4_qmo", 32'(q_msb_o), 32'h1);
    advance();
    drive(ins(1, 3, 2), 0, 0, 0, 0);
    eval_check();
    chk("tp4_q", 32'(y), 32'h0);
    advance();

    // Repeat loop: B3 = B3 + 2, count 3, live inputs scrambled during the loop
    bcnt = 0; dcnt = 0;
    drive(ins(3, 0, 5), 3, 3, 2, 0);
    start = 1'b1;
    count = 6'd3;
    eval_check();
    bcnt += int'(busy); dcnt += int'(done);
    advance();
    for (int n = 0; n < 6; n++) begin
      drive(ins(1, $urandom % 8, $urandom % 8), $urandom % 16, $urandom % 16, $urandom, 1'($urandom));
      eval_check();
      bcnt += int'(busy); dcnt += int'(done);
      advance();
    end
    drive(ins(1, 3, 3), 0, 3, 0, 0);
    eval_check();
`ifdef ALU_SLICE_RPT_REPEAT_EN
    chk("tp5_b", 32'(y), 32'h8);
    chk("tp5_busy_cyc", 32'(bcnt), 32'd3);
`else
    chk("tp5_b", 32'(y), 32'h2);
    chk("tp5_busy_cyc", 32'(bcnt), 32'd0);
`endif
    chk("tp5_done_cnt", 32'(dcnt), 32'd1);
    advance();

    // Reset in the middle of a loop
    drive(ins(0, 0, 7), 0, 0, 16'hBEEF, 0);
    eval_check();
    advance();
    drive(ins(3, 0, 5), 4, 4, 1, 0);
    start = 1'b1;
    count = 6'd5;
    eval_check();
    advance();
    drive(ins(1, 3, 2), 0, 0, 0, 0);
    eval_check();
    advance();
    #2;
    rst_n = 1'b0;
    #1;
    chk("tp6_y", 32'(y), 32'h0);
    chk("tp6_busy", 32'(busy), 32'h0);
    chk("tp6_done", 32'(done), 32'h0);
    mq = 0;
    m_left = 0;
    @(negedge clk);
    chk("tp6_hold", {30'h0, busy, done}, 32'h0);
    rst_n = 1'b1;
    drive(ins(3, 0, 5), 4, 4, 1, 0);
    start = 1'b1;
    count = 6'd2;
    eval_check();
    advance();
    for (int n = 0; n < 4; n++) begin
      drive(ins(1, 3, 3), 0, 4, 0, 0);
      eval_check();
      advance();
    end

    // Random microinstructions
    for (int n = 0; n < 1500; n++) begin
      i = 9'($urandom);
      a_addr = 4'($urandom);
      b_addr = 4'($urandom);
      d = 16'($urandom);
      cin = 1'($urandom);
      oe_n = ($urandom % 8) == 0;
      ram_lsb_i = 1'($urandom); ram_msb_i = 1'($urandom);
      q_lsb_i = 1'($urandom);   q_msb_i = 1'($urandom);
      start = ($urandom % 6) == 0;
      count = 6'($urandom % 5);
      eval_check();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
